// File: rtl/midi_pkg.sv
// Shared MIDI definitions: line rate, status classes, message length decode, TX FSM encoding.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package midi_pkg;

   localparam int MIDI_BAUD = 31250;

   // Upper nibble of a status byte selects the message class
   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CHAN_AT  = 4'hD;
   localparam logic [3:0] PITCH    = 4'hE;
   localparam logic [3:0] SYS      = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // Total bytes on the wire for a full (uncompressed) message, 1..3
   function automatic logic [1:0] msg_len(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd1;
      case (status[7:4])
         NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: len = 2'd3;
         PROG, CHAN_AT:                         len = 2'd2;
         default: begin
            if (status == 8'hF2)                         len = 2'd3;
            else if (status == 8'hF1 || status == 8'hF3) len = 2'd2;
            else                                         len = 2'd1;
         end
      endcase
      return len;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT cycles each.
// Latency: line falls on the edge after i_start is seen in idle or in the final stop cycle.
// Backpressure: i_start is only taken in idle or on the last stop cycle (o_done), giving gap-free frames.
module uart_tx_byte
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1600
) (
   input  logic       IN_CLOCK,
   input  logic       IN_RESET,
   input  logic [7:0] i_byte,
   input  logic       i_start,
   output logic       o_tx,
   output logic       o_busy,
   output logic       o_done
);
   localparam logic [10:0] RELOAD = 11'(CLKS_PER_BIT - 1);

   tx_state_t   r_state, w_state;
   logic [10:0] r_timer, w_timer;
   logic [2:0]  r_bit,   w_bit;
   logic [7:0]  r_shift, w_shift;
   logic        r_tx,    w_tx;
   logic        w_tick;
   logic        w_done;

   assign w_tick = (r_timer == 11'd0);

   // State, timer, bit counter, shift register and registered line output
   always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
      if (!IN_RESET) begin
         r_state <= ST_IDLE;
         r_timer <= RELOAD;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state;
         r_timer <= w_timer;
         r_bit   <= w_bit;
         r_shift <= w_shift;
         r_tx    <= w_tx;
      end
   end

   // Next-state: each phase lasts one bit time; the line value is computed one cycle ahead
   always_comb begin
      w_state = r_state;
      w_timer = r_timer - 11'd1;
      w_bit   = r_bit;
      w_shift = r_shift;
      w_tx    = r_tx;
      w_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_timer = RELOAD;
            w_tx    = 1'b1;
            if (i_start) begin
               w_state = ST_START;
               w_shift = i_byte;
               w_tx    = 1'b0;
            end
         end
         ST_START: begin
            if (w_tick) begin
               w_state = ST_DATA;
               w_timer = RELOAD;
               w_bit   = 3'd0;
               w_tx    = r_shift[0];
               w_shift = {1'b0, r_shift[7:1]};
            end
         end
         ST_DATA: begin
            if (w_tick) begin
               w_timer = RELOAD;
               if (r_bit == 3'd7) begin
                  w_state = ST_STOP;
                  w_tx    = 1'b1;
               end else begin
                  w_bit   = r_bit + 3'd1;
                  w_tx    = r_shift[0];
                  w_shift = {1'b0, r_shift[7:1]};
               end
            end
         end
         ST_STOP: begin
            if (w_tick) begin
               w_done  = 1'b1;
               w_timer = RELOAD;
               if (i_start) begin
                  w_state = ST_START;
                  w_shift = i_byte;
                  w_tx    = 1'b0;
               end else begin
                  w_state = ST_IDLE;
                  w_tx    = 1'b1;
               end
            end
         end
         default: begin
            w_state = ST_IDLE;
            w_tx    = 1'b1;
         end
      endcase
   end

   assign o_tx   = r_tx;
   assign o_busy = (r_state != ST_IDLE);
   assign o_done = w_done;

endmodule

// File: rtl/midi_out_tx.sv
// MIDI OUT: takes one whole message per valid/ready handshake and sends it as 8N1 bytes.
// Latency: line falls one cycle after the accepting edge; bytes follow back-to-back, 10 bit times each.
// Backpressure: OUT_READY low from acceptance until the final stop bit has finished.
module midi_out_tx
   import midi_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int BAUD           = MIDI_BAUD,
   parameter int RUNNING_STATUS = 1
) (
   input  logic       IN_CLOCK,
   input  logic       IN_RESET,
   input  logic [7:0] IN_STATUS,
   input  logic [6:0] IN_DATA1,
   input  logic [6:0] IN_DATA2,
   input  logic       IN_VALID,
   output logic       OUT_READY,
   output logic       OUT_TX,
   output logic       OUT_BUSY,
   output logic       OUT_DONE,
   output logic       OUT_ERROR
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   if (CLK_HZ % BAUD != 0) begin : g_bad_ratio
      $error("midi_out_tx: CLK_HZ must be an exact multiple of BAUD");
   end
   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 2048) begin : g_bad_range
      $error("midi_out_tx: CLKS_PER_BIT must fit the 11-bit bit timer");
   end

   logic       r_active;
   logic [7:0] r_status;
   logic [6:0] r_data1, r_data2;
   logic [1:0] r_idx, r_last_idx;
   logic [7:0] r_cache;
   logic       r_cache_vld;
   logic       r_error;

   logic       w_accept, w_good, w_bad, w_chan, w_skip, w_more;
   logic       w_byte_done, w_uart_busy, w_uart_start, w_uart_tx;
   logic [1:0] w_len, w_send_idx;
   logic [7:0] w_send_byte;

   assign w_accept = IN_VALID && !r_active;
   assign w_good   = w_accept && IN_STATUS[7];
   assign w_bad    = w_accept && !IN_STATUS[7];
   assign w_chan   = (IN_STATUS[7:4] != SYS);
   assign w_skip   = (RUNNING_STATUS != 0) && w_chan && r_cache_vld && (r_cache == IN_STATUS);
   assign w_len    = msg_len(IN_STATUS);
   assign w_more   = (r_idx != r_last_idx);

   // First byte starts from idle; later bytes are chained on the last stop cycle so no gap appears
   assign w_uart_start = r_active && (!w_uart_busy || (w_byte_done && w_more));
   assign w_send_idx   = w_byte_done ? r_idx + 2'd1 : r_idx;

   // Byte selection: index 0 is the status, 1 and 2 the data bytes
   always_comb begin
      w_send_byte = r_status;
      case (w_send_idx)
         2'd1:    w_send_byte = {1'b0, r_data1};
         2'd2:    w_send_byte = {1'b0, r_data2};
         default: w_send_byte = r_status;
      endcase
   end

   // Message capture and byte sequencing
   always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
      if (!IN_RESET) begin
         r_active   <= 1'b0;
         r_status   <= 8'd0;
         r_data1    <= 7'd0;
         r_data2    <= 7'd0;
         r_idx      <= 2'd0;
         r_last_idx <= 2'd0;
         r_error    <= 1'b0;
      end else begin
         r_error <= w_bad;
         if (w_good) begin
            r_active   <= 1'b1;
            r_status   <= IN_STATUS;
            r_data1    <= IN_DATA1;
            r_data2    <= IN_DATA2;
            r_idx      <= w_skip ? 2'd1 : 2'd0;
            r_last_idx <= w_len - 2'd1;
         end else if (w_byte_done) begin
            if (w_more) r_idx    <= r_idx + 2'd1;
            else        r_active <= 1'b0;
         end
      end
   end

   // Running-status cache: channel messages load it, system common clears it, realtime leaves it
   always_ff @(posedge IN_CLOCK or negedge IN_RESET) begin
      if (!IN_RESET) begin
         r_cache     <= 8'd0;
         r_cache_vld <= 1'b0;
      end else if (w_good) begin
         if (w_chan) begin
            r_cache     <= IN_STATUS;
            r_cache_vld <= 1'b1;
         end else if (!IN_STATUS[3]) begin
            r_cache_vld <= 1'b0;
         end
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart (
      .IN_CLOCK (IN_CLOCK),
      .IN_RESET (IN_RESET),
      .i_byte   (w_send_byte),
      .i_start  (w_uart_start),
      .o_tx     (w_uart_tx),
      .o_busy   (w_uart_busy),
      .o_done   (w_byte_done)
   );

   assign OUT_READY = !r_active;
   assign OUT_BUSY  = r_active;
   assign OUT_DONE  = r_active && w_byte_done && !w_more;
   assign OUT_ERROR = r_error;
   assign OUT_TX    = w_uart_tx;

endmodule

// File: tb/tb_midi_out_tx.sv
// Bench for midi_out_tx at a reduced clock (16 clocks per bit) with and without running status.
module tb_midi_out_tx;

   localparam int CLK_HZ   = 500_000;
   localparam int CPB      = 16;
   localparam int BYTE_CYC = 10 * CPB;

   typedef struct {
      logic [7:0] st;
      logic [6:0] d1;
      logic [6:0] d2;
      int         nb;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] e2;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_status;
   logic [6:0] in_d1, in_d2;
   logic       valid_rs, valid_nrs;
   logic       rdy_rs, tx_rs, busy_rs, done_rs, err_rs;
   logic       rdy_nrs, tx_nrs, busy_nrs, done_nrs, err_nrs;
   logic       mute;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   vec_t       tbl[21];

   always #5 clk = ~clk;

   midi_out_tx #(.CLK_HZ(CLK_HZ), .BAUD(31250), .RUNNING_STATUS(1)) dut_rs (
      .IN_CLOCK(clk), .IN_RESET(rst_n), .IN_STATUS(in_status), .IN_DATA1(in_d1),
      .IN_DATA2(in_d2), .IN_VALID(valid_rs), .OUT_READY(rdy_rs), .OUT_TX(tx_rs),
      .OUT_BUSY(busy_rs), .OUT_DONE(done_rs), .OUT_ERROR(err_rs));

   midi_out_tx #(.CLK_HZ(CLK_HZ), .BAUD(31250), .RUNNING_STATUS(0)) dut_nrs (
      .IN_CLOCK(clk), .IN_RESET(rst_n), .IN_STATUS(in_status), .IN_DATA1(in_d1),
      .IN_DATA2(in_d2), .IN_VALID(valid_nrs), .OUT_READY(rdy_nrs), .OUT_TX(tx_nrs),
      .OUT_BUSY(busy_nrs), .OUT_DONE(done_nrs), .OUT_ERROR(err_nrs));

   function automatic logic f_tx(input int w);   return (w == 0) ? tx_rs   : tx_nrs;   endfunction
   function automatic logic f_rdy(input int w);  return (w == 0) ? rdy_rs  : rdy_nrs;  endfunction
   function automatic logic f_busy(input int w); return (w == 0) ? busy_rs : busy_nrs; endfunction
   function automatic logic f_done(input int w); return (w == 0) ? done_rs : done_nrs; endfunction
   function automatic logic f_err(input int w);  return (w == 0) ? err_rs  : err_nrs;  endfunction

   task automatic set_valid(input int w, input logic v);
      if (w == 0) valid_rs = v;
      else        valid_nrs = v;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Line receiver: samples mid-bit on falling clock edges, checks each byte against the queue
   task automatic monitor(input int w);
      logic [7:0] b;
      logic [7:0] e;
      forever begin
         do @(negedge clk); while (f_tx(w) !== 1'b0);
         repeat (CPB / 2 - 1) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = f_tx(w);
         end
         repeat (CPB) @(negedge clk);
         if (!mute) begin
            chk($sformatf("rx%0d stop bit", w), f_tx(w), 1);
            if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
               n_vec++;
               n_err++;
               $display("FAIL rx%0d unexpected byte: got %02h, none expected", w, b);
            end else begin
               e = (w == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("rx%0d byte", w), b, e);
            end
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   task automatic wait_ready(input int w, input string tag);
      int t = 0;
      while (!f_rdy(w) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, " ready before send"}, f_rdy(w), 1);
   endtask

   // Called on the falling edge right after the accepting edge (k = 0)
   task automatic wait_done(input int w, input int nb, input string tag);
      int   k = 0;
      logic seen = 1'b0;
      chk({tag, " tx high at accept"}, f_tx(w), 1);
      chk({tag, " busy"}, f_busy(w), 1);
      chk({tag, " ready low"}, f_rdy(w), 0);
      while (!seen && k < nb * BYTE_CYC + 50) begin
         @(posedge clk);
         @(negedge clk);
         k++;
         if (k == 1) chk({tag, " tx falls"}, f_tx(w), 0);
         if (f_done(w)) seen = 1'b1;
      end
      chk({tag, " done cycle"}, k, nb * BYTE_CYC);
      @(posedge clk);
      @(negedge clk);
      chk({tag, " ready after"}, f_rdy(w), 1);
      chk({tag, " done one cycle"}, f_done(w), 0);
   endtask

   task automatic run_msg(input int w, input logic [7:0] st, input logic [6:0] d1,
                          input logic [6:0] d2, input int nb, input string tag);
      wait_ready(w, tag);
      in_status = st;
      in_d1     = d1;
      in_d2     = d2;
      set_valid(w, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_valid(w, 1'b0);
      if (nb == 0) begin
         chk({tag, " error pulse"}, f_err(w), 1);
         chk({tag, " ready stays"}, f_rdy(w), 1);
         chk({tag, " busy stays low"}, f_busy(w), 0);
         @(posedge clk);
         @(negedge clk);
         chk({tag, " error one cycle"}, f_err(w), 0);
         chk({tag, " tx idle"}, f_tx(w), 1);
      end else begin
         wait_done(w, nb, tag);
      end
   endtask

   initial begin
      int   t;
      logic err_seen;

      tbl[0]  = '{8'h90, 7'h3C, 7'h64, 3, 8'h90, 8'h3C, 8'h64};
      tbl[1]  = '{8'h90, 7'h40, 7'h00, 2, 8'h40, 8'h00, 8'h00};
      tbl[2]  = '{8'hC5, 7'h0A, 7'h00, 2, 8'hC5, 8'h0A, 8'h00};
      tbl[3]  = '{8'h90, 7'h3C, 7'h64, 3, 8'h90, 8'h3C, 8'h64};
      tbl[4]  = '{8'hF8, 7'h00, 7'h00, 1, 8'hF8, 8'h00, 8'h00};
      tbl[5]  = '{8'h90, 7'h3C, 7'h64, 2, 8'h3C, 8'h64, 8'h00};
      tbl[6]  = '{8'h3C, 7'h00, 7'h00, 0, 8'h00, 8'h00, 8'h00};
      tbl[7]  = '{8'h90, 7'h01, 7'h02, 2, 8'h01, 8'h02, 8'h00};
      tbl[8]  = '{8'hF2, 7'h01, 7'h02, 3, 8'hF2, 8'h01, 8'h02};
      tbl[9]  = '{8'h90, 7'h11, 7'h22, 3, 8'h90, 8'h11, 8'h22};
      tbl[10] = '{8'hD3, 7'h05, 7'h00, 2, 8'hD3, 8'h05, 8'h00};
      tbl[11] = '{8'hD3, 7'h06, 7'h00, 1, 8'h06, 8'h00, 8'h00};
      tbl[12] = '{8'hF1, 7'h7F, 7'h00, 2, 8'hF1, 8'h7F, 8'h00};
      tbl[13] = '{8'hD3, 7'h07, 7'h00, 2, 8'hD3, 8'h07, 8'h00};
      tbl[14] = '{8'hFE, 7'h00, 7'h00, 1, 8'hFE, 8'h00, 8'h00};
      tbl[15] = '{8'hD3, 7'h08, 7'h00, 1, 8'h08, 8'h00, 8'h00};
      tbl[16] = '{8'hE0, 7'h00, 7'h40, 3, 8'hE0, 8'h00, 8'h40};
      tbl[17] = '{8'hF6, 7'h00, 7'h00, 1, 8'hF6, 8'h00, 8'h00};
      tbl[18] = '{8'hB0, 7'h07, 7'h64, 3, 8'hB0, 8'h07, 8'h64};
      tbl[19] = '{8'hF3, 7'h05, 7'h00, 2, 8'hF3, 8'h05, 8'h00};
      tbl[20] = '{8'hB0, 7'h07, 7'h7F, 3, 8'hB0, 8'h07, 8'h7F};

      rst_n     = 1'b0;
      mute      = 1'b0;
      valid_rs  = 1'b0;
      valid_nrs = 1'b0;
      in_status = 8'h00;
      in_d1     = 7'h00;
      in_d2     = 7'h00;
      #12;
      chk("reset outputs rs",  {tx_rs,  rdy_rs,  busy_rs,  done_rs,  err_rs},  5'b11000);
      chk("reset outputs nrs", {tx_nrs, rdy_nrs, busy_nrs, done_nrs, err_nrs}, 5'b11000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Without compression every message carries its status byte
      q1.push_back(8'h90); q1.push_back(8'h3C); q1.push_back(8'h64);
      run_msg(1, 8'h90, 7'h3C, 7'h64, 3, "nrs first");
      q1.push_back(8'h90); q1.push_back(8'h40); q1.push_back(8'h00);
      run_msg(1, 8'h90, 7'h40, 7'h00, 3, "nrs repeat");

      for (int i = 0; i < 21; i++) begin
         if (tbl[i].nb > 0) q0.push_back(tbl[i].e0);
         if (tbl[i].nb > 1) q0.push_back(tbl[i].e1);
         if (tbl[i].nb > 2) q0.push_back(tbl[i].e2);
         run_msg(0, tbl[i].st, tbl[i].d1, tbl[i].d2, tbl[i].nb, $sformatf("vec%0d", i));
      end

      // Reset in the middle of a frame, then the status byte must be resent
      mute = 1'b1;
      wait_ready(0, "abort");
      in_status = 8'h90; in_d1 = 7'h3C; in_d2 = 7'h64; valid_rs = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid_rs = 1'b0;
      repeat (50) @(negedge clk);
      chk("abort mid-frame tx low", tx_rs, 0);
      chk("abort mid-frame busy", busy_rs, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort tx high", tx_rs, 1);
      chk("abort ready", rdy_rs, 1);
      chk("abort busy low", busy_rs, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      mute = 1'b0;
      q0.push_back(8'h90); q0.push_back(8'h3C); q0.push_back(8'h64);
      run_msg(0, 8'h90, 7'h3C, 7'h64, 3, "after abort");

      // Valid held high through a frame while the inputs churn
      q0.push_back(8'h12); q0.push_back(8'h34);
      wait_ready(0, "hold");
      in_status = 8'h90; in_d1 = 7'h12; in_d2 = 7'h34; valid_rs = 1'b1;
      @(posedge clk);
      @(negedge clk);
      t = 0;
      err_seen = 1'b0;
      while (!rdy_rs && t < 1000) begin
         if (err_rs) err_seen = 1'b1;
         in_status = 8'($urandom);
         in_d1     = 7'($urandom);
         in_d2     = 7'($urandom);
         @(posedge clk);
         @(negedge clk);
         t++;
      end
      chk("hold no error", err_seen, 0);
      chk("hold ready cycle", t, 2 * BYTE_CYC + 1);
      in_status = 8'hF2; in_d1 = 7'h01; in_d2 = 7'h02;
      q0.push_back(8'hF2); q0.push_back(8'h01); q0.push_back(8'h02);
      @(posedge clk);
      @(negedge clk);
      valid_rs = 1'b0;
      wait_done(0, 3, "hold f2");
      q0.push_back(8'h90); q0.push_back(8'h55); q0.push_back(8'h66);
      run_msg(0, 8'h90, 7'h55, 7'h66, 3, "after f2");

      repeat (20) @(negedge clk);
      chk("rx0 drained", q0.size(), 0);
      chk("rx1 drained", q1.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
